pe_seq_driver: RTL and testbench

- Host-side sequencer for a single PE: it is the driving end of the PE load/start/sums protocol.
- Buffers incoming weight, activation and upstream-psum streams (valid/ready) and replays them to the PE as gap-free bursts.
- Pulses start, waits for compute completion, runs the systolic sum pass, and forwards the summed psums downstream.
- Sits between the cluster's multicast/router fabric and one PE instance.

---
 rtl/pe_seq_driver.sv | 238 +++++++++++++++++++++++
 tb/tb_pe_seq_driver.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_driver.sv
// pe_seq_driver: buffers weight/act/psum streams and sequences one PE through load, start, sum and drain.
module pe_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, push;
  always_comb begin
    push = in_valid && ready_q;
    wp_d = push ? ((wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = pop ? ((rp_q == AW'(DEPTH - 1)) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ready_d = cnt_d < CW'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
    end
  end
  always_ff @(posedge clk) if (push) mem[wp_q] <= in_data;
  assign in_ready = ready_q;
  assign head = mem[rp_q];
  assign count = cnt_q;
endmodule

module pe_seq_driver #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 16,
  parameter int PSUM_W   = 2 * DATA_W + 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_acount,
  input  logic [7:0]        cfg_wcount,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [PSUM_W-1:0] p_data,
  output logic              o_valid,
  output logic [PSUM_W-1:0] o_data,
  output logic [DATA_W-1:0] pe_weights,
  output logic [DATA_W-1:0] pe_acts,
  output logic [PSUM_W-1:0] pe_psum,
  output logic              pe_loadw,
  output logic              pe_loada,
  output logic              pe_start,
  output logic              pe_sums,
  output logic [7:0]        pe_acount,
  output logic [7:0]        pe_wcount,
  input  logic [PSUM_W-1:0] pe_psum_in,
  input  logic              pe_psum_valid,
  input  logic              pe_done,
  output logic              busy,
  output logic              err,
  output logic              job_done
);
  localparam int CW = $clog2(RF_DEPTH + 1);
  typedef enum logic [3:0] {IDLE, FILL, LOAD, GAP, START, WAIT, PFILL, SUM, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, ocnt_q, ocnt_d, acount_q, acount_d, wcount_q, wcount_d, ocount;
  logic cfg_ready_q, cfg_ready_d, busy_q, busy_d, err_q, err_d, job_done_q, job_done_d;
  logic o_valid_q, o_valid_d, loadw_q, loadw_d, loada_q, loada_d, start_q, start_d, sums_q, sums_d;
  logic [PSUM_W-1:0] o_data_q, o_data_d, psum_q, psum_d, p_head;
  logic [DATA_W-1:0] weights_q, weights_d, acts_q, acts_d, w_head, a_head;
  logic [CW-1:0] w_cnt, a_cnt, p_cnt;
  logic w_pop, a_pop, p_pop, cfg_ok;

  pe_seq_fifo #(.W(DATA_W), .DEPTH(RF_DEPTH)) u_wf (.clk(clk), .nrst(nrst), .in_valid(w_valid), .in_ready(w_ready),
    .in_data(w_data), .pop(w_pop), .head(w_head), .count(w_cnt));
  pe_seq_fifo #(.W(DATA_W), .DEPTH(RF_DEPTH)) u_af (.clk(clk), .nrst(nrst), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .pop(a_pop), .head(a_head), .count(a_cnt));
  pe_seq_fifo #(.W(PSUM_W), .DEPTH(RF_DEPTH)) u_pf (.clk(clk), .nrst(nrst), .in_valid(p_valid), .in_ready(p_ready),
    .in_data(p_data), .pop(p_pop), .head(p_head), .count(p_cnt));

  assign ocount = acount_q - wcount_q + 8'd1;
  assign cfg_ok = cfg_wcount != 8'd0 && cfg_wcount <= cfg_acount && cfg_acount <= 8'(RF_DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ocnt_d = ocnt_q;
    acount_d = acount_q;
    wcount_d = wcount_q;
    err_d = 1'b0;
    job_done_d = 1'b0;
    o_valid_d = 1'b0;
    o_data_d = '0;
    loadw_d = 1'b0;
    loada_d = 1'b0;
    start_d = 1'b0;
    sums_d = 1'b0;
    weights_d = '0;
    acts_d = '0;
    psum_d = '0;
    w_pop = 1'b0;
    a_pop = 1'b0;
    p_pop = 1'b0;
    case (state_q)
      IDLE: if (cfg_valid && cfg_ready_q) begin
        err_d = !cfg_ok;
        acount_d = cfg_ok ? cfg_acount : acount_q;
        wcount_d = cfg_ok ? cfg_wcount : wcount_q;
        state_d = cfg_ok ? FILL : IDLE;
      end
      FILL: if (8'(w_cnt) >= wcount_q && 8'(a_cnt) >= acount_q) begin
        state_d = LOAD;
        cnt_d = '0;
      end
      LOAD: begin
        a_pop = 1'b1;
        loada_d = 1'b1;
        acts_d = a_head;
        w_pop = cnt_q < wcount_q;
        loadw_d = w_pop;
        weights_d = w_pop ? w_head : '0;
        cnt_d = cnt_q + 8'd1;
        state_d = (cnt_q == acount_q - 8'd1) ? GAP : LOAD;
      end
      GAP: state_d = START;
      START: begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: state_d = pe_done ? PFILL : WAIT;
      PFILL: if (8'(p_cnt) >= ocount) begin
        state_d = SUM;
        cnt_d = '0;
        ocnt_d = '0;
      end
      SUM: begin
        p_pop = 1'b1;
        sums_d = 1'b1;
        psum_d = p_head;
        cnt_d = cnt_q + 8'd1;
        state_d = (cnt_q == ocount - 8'd1) ? DRAIN : SUM;
      end
      DRAIN: if (ocnt_q == ocount) begin
        job_done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The PE answers while later sums are still being issued, so results are collected in SUM too.
    if ((state_q == SUM || state_q == DRAIN) && pe_psum_valid && ocnt_q != ocount) begin
      o_valid_d = 1'b1;
      o_data_d = pe_psum_in;
      ocnt_d = ocnt_q + 8'd1;
    end
    cfg_ready_d = state_q == IDLE && state_d == IDLE;
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ocnt_q <= '0;
      acount_q <= '0;
      wcount_q <= '0;
      cfg_ready_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      job_done_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q <= '0;
      loadw_q <= 1'b0;
      loada_q <= 1'b0;
      start_q <= 1'b0;
      sums_q <= 1'b0;
      weights_q <= '0;
      acts_q <= '0;
      psum_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ocnt_q <= ocnt_d;
      acount_q <= acount_d;
      wcount_q <= wcount_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q <= busy_d;
      err_q <= err_d;
      job_done_q <= job_done_d;
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
      loadw_q <= loadw_d;
      loada_q <= loada_d;
      start_q <= start_d;
      sums_q <= sums_d;
      weights_q <= weights_d;
      acts_q <= acts_d;
      psum_q <= psum_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy = busy_q;
  assign err = err_q;
  assign job_done = job_done_q;
  assign o_valid = o_valid_q;
  assign o_data = o_data_q;
  assign pe_loadw = loadw_q;
  assign pe_loada = loada_q;
  assign pe_start = start_q;
  assign pe_sums = sums_q;
  assign pe_weights = weights_q;
  assign pe_acts = acts_q;
  assign pe_psum = psum_q;
  assign pe_acount = acount_q;
  assign pe_wcount = wcount_q;
endmodule

// File: tb/tb_pe_seq_driver.sv
// tb_pe_seq_driver: directed jobs against a behavioural PE, with a scoreboard of expected psum outputs.
module tb_pe_seq_driver;
  logic clk, nrst, cfg_valid, cfg_ready, w_valid, w_ready, a_valid, a_ready, p_valid, p_ready;
  logic [7:0] cfg_acount, cfg_wcount, w_data, a_data, pe_weights, pe_acts, pe_acount, pe_wcount;
  logic [19:0] p_data, o_data, pe_psum, pe_psum_in;
  logic o_valid, pe_loadw, pe_loada, pe_start, pe_sums, pe_psum_valid, pe_done, busy, err, job_done;

  pe_seq_driver dut (
    .clk(clk), .nrst(nrst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_acount(cfg_acount), .cfg_wcount(cfg_wcount),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
    .o_valid(o_valid), .o_data(o_data), .pe_weights(pe_weights), .pe_acts(pe_acts), .pe_psum(pe_psum),
    .pe_loadw(pe_loadw), .pe_loada(pe_loada), .pe_start(pe_start), .pe_sums(pe_sums),
    .pe_acount(pe_acount), .pe_wcount(pe_wcount), .pe_psum_in(pe_psum_in),
    .pe_psum_valid(pe_psum_valid), .pe_done(pe_done), .busy(busy), .err(err), .job_done(job_done)
  );

  int tests = 0, fails = 0, cyc = 0;
  int wgap = 0, agap = 0, w_sent = 0, a_sent = 0;
  int o_cnt, lw_cyc, lw_rise, la_cyc, la_rise, st_cyc, gap_ok, sums_cyc, sums_t, ov_t;
  int jd, jd1_t, er, busy_cyc, tog, acc_t, la_t, w_at, a_at;
  logic p_lw = 0, p_la = 0, pp_la = 0, p_sums = 0, p_any = 0;
  logic [7:0] wq[$], aq[$];
  logic [19:0] pq[$], exp_q[$];
  logic [7:0] sw[16], sa[16];
  logic [19:0] res[16];

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    o_cnt = 0; lw_cyc = 0; lw_rise = 0; la_cyc = 0; la_rise = 0; st_cyc = 0; gap_ok = 0;
    sums_cyc = 0; sums_t = -1; ov_t = -1; jd = 0; jd1_t = -1; er = 0; busy_cyc = 0; tog = 0;
    acc_t = -1; la_t = -1; w_at = -1; a_at = -1; w_sent = 0; a_sent = 0;
  endtask

  function automatic int conv(int i);
    int s = 0;
    for (int j = 0; j < int'(pe_wcount); j++)
      if (i + j < 16) s += int'($signed(sw[j])) * int'($signed(sa[i + j]));
    return s;
  endfunction

  // Behavioural PE: spad addresses restart whenever a load strobe drops.
  initial begin
    int wa = 0, aa = 0, si = 0, dcnt = 0;
    pe_done = 0; pe_psum_valid = 0; pe_psum_in = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!nrst) begin
        wa = 0; aa = 0; si = 0; dcnt = 0;
        pe_done <= 0; pe_psum_valid <= 0; pe_psum_in <= '0;
      end else begin
        if (pe_loadw) begin if (wa < 16) sw[wa] = pe_weights; wa++; end else wa = 0;
        if (pe_loada) begin if (aa < 16) sa[aa] = pe_acts; aa++; end else aa = 0;
        pe_done <= (dcnt == 1);
        if (dcnt > 0) dcnt--;
        if (pe_start) begin
          for (int i = 0; i < 16; i++) res[i] = 20'(conv(i));
          dcnt = 4;
        end
        if (pe_sums) begin
          pe_psum_valid <= 1; pe_psum_in <= res[si[3:0]] + pe_psum; si++;
        end else begin
          si = 0; pe_psum_valid <= 0;
        end
      end
    end
  end

  initial begin
    int gc = 0;
    bit fire = 0;
    w_valid = 0; w_data = '0;
    forever begin
      @(negedge clk);
      if (w_valid && fire) begin w_valid = 0; w_sent++; gc = wgap; end
      if (!w_valid && wq.size() > 0) begin
        if (gc > 0) gc--; else begin w_data = wq.pop_front(); w_valid = 1; end
      end
      fire = w_ready && nrst;
    end
  end

  initial begin
    int gc = 0;
    bit fire = 0;
    a_valid = 0; a_data = '0;
    forever begin
      @(negedge clk);
      if (a_valid && fire) begin a_valid = 0; a_sent++; gc = agap; end
      if (!a_valid && aq.size() > 0) begin
        if (gc > 0) gc--; else begin a_data = aq.pop_front(); a_valid = 1; end
      end
      fire = a_ready && nrst;
    end
  end

  initial begin
    bit fire = 0;
    p_valid = 0; p_data = '0;
    forever begin
      @(negedge clk);
      if (p_valid && fire) p_valid = 0;
      if (!p_valid && pq.size() > 0) begin p_data = pq.pop_front(); p_valid = 1; end
      fire = p_ready && nrst;
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (o_valid) begin
        o_cnt++;
        if (o_cnt == 1) ov_t = cyc;
        if (exp_q.size() > 0) chk("o_data", 64'(o_data), 64'(exp_q.pop_front()));
        else chk("o_spurious", 64'(o_valid), 64'(0));
      end
      lw_cyc += int'(pe_loadw); lw_rise += int'(pe_loadw && !p_lw);
      la_cyc += int'(pe_loada); la_rise += int'(pe_loada && !p_la);
      if (pe_loada && !p_la) begin w_at = w_sent; a_at = a_sent; la_t = cyc; end
      if (pe_start) begin st_cyc++; if (!p_any && pp_la) gap_ok++; end
      if (pe_sums) begin sums_cyc++; if (!p_sums && sums_t < 0) sums_t = cyc; end
      if (job_done && jd == 0) jd1_t = cyc;
      jd += int'(job_done); er += int'(err); busy_cyc += int'(busy);
      if (cfg_valid && cfg_ready) acc_t = cyc;
      tog += int'(pe_loadw | pe_loada | pe_start | pe_sums);
      pp_la = p_la; p_lw = pe_loadw; p_la = pe_loada; p_sums = pe_sums;
      p_any = pe_loadw | pe_loada | pe_start | pe_sums;
    end
  end

  task automatic send_cfg(input logic [7:0] ac, input logic [7:0] wc);
    int t = 0;
    @(negedge clk);
    cfg_valid = 1; cfg_acount = ac; cfg_wcount = wc;
    while (!cfg_ready && t < 300) begin @(negedge clk); t++; end
    chk("cfg_accept_tmo", 64'(t < 300), 64'(1));
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic wait_jobs(input int n);
    int t = 0;
    while (jd < n && t < 3000) begin @(negedge clk); t++; end
    chk("job_done_tmo", 64'(jd >= n), 64'(1));
    @(negedge clk);
  endtask

  task automatic job(input logic [7:0] ac, input logic [7:0] wc);
    send_cfg(ac, wc);
    wait_jobs(1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic push_basic(input logic [19:0] p0, input logic [19:0] p1, input logic [19:0] p2);
    wq.push_back(8'd1); wq.push_back(8'd2); wq.push_back(8'd3);
    for (int i = 1; i <= 5; i++) aq.push_back(8'(i));
    pq.push_back(p0); pq.push_back(p1); pq.push_back(p2);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({o_valid, busy, err, job_done, pe_loadw, pe_loada, pe_start, pe_sums,
                            cfg_ready, w_ready, a_ready, p_ready}), 64'(0));
    chk({tag, "_psum"}, 64'({o_data, pe_psum}), 64'(0));
    chk({tag, "_data"}, 64'({pe_weights, pe_acts, pe_acount, pe_wcount}), 64'(0));
  endtask

  initial begin
    int n;
    nrst = 0; cfg_valid = 0; cfg_acount = '0; cfg_wcount = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    nrst = 1;
    repeat (2) @(negedge clk);
    chk("idle_cfg_ready", 64'(cfg_ready), 64'(1));

    // Basic job: 14,20,26 with strobe-shape checks
    clear_mon();
    push_basic(20'd0, 20'd0, 20'd0);
    exp_q.push_back(20'd14); exp_q.push_back(20'd20); exp_q.push_back(20'd26);
    job(8'd5, 8'd3);
    chk("basic_outs", 64'(o_cnt), 64'(3));
    chk("basic_loadw_cycles", 64'(lw_cyc), 64'(3));
    chk("basic_loadw_bursts", 64'(lw_rise), 64'(1));
    chk("basic_loada_cycles", 64'(la_cyc), 64'(5));
    chk("basic_loada_bursts", 64'(la_rise), 64'(1));
    chk("basic_start_pulses", 64'(st_cyc), 64'(1));
    chk("basic_gap", 64'(gap_ok), 64'(1));
    chk("basic_sums_cycles", 64'(sums_cyc), 64'(3));
    chk("basic_latency", 64'(ov_t - sums_t), 64'(2));
    chk("basic_job_done", 64'(jd), 64'(1));
    chk("basic_cfg_latch", 64'({pe_acount, pe_wcount}), 64'({8'd5, 8'd3}));

    // Upstream psums
    clear_mon();
    push_basic(20'd100, 20'd200, 20'd300);
    exp_q.push_back(20'd114); exp_q.push_back(20'd220); exp_q.push_back(20'd326);
    job(8'd5, 8'd3);
    chk("upstream_outs", 64'(o_cnt), 64'(3));

    // Signed weights
    clear_mon();
    repeat (3) wq.push_back(8'hFF);
    for (int i = 1; i <= 5; i++) aq.push_back(8'(i));
    repeat (3) pq.push_back(20'd0);
    exp_q.push_back(20'hFFFFA); exp_q.push_back(20'hFFFF7); exp_q.push_back(20'hFFFF4);
    job(8'd5, 8'd3);
    chk("signed_outs", 64'(o_cnt), 64'(3));

    // Stalled streams
    clear_mon();
    wgap = 2; agap = 1;
    push_basic(20'd0, 20'd0, 20'd0);
    exp_q.push_back(20'd14); exp_q.push_back(20'd20); exp_q.push_back(20'd26);
    job(8'd5, 8'd3);
    wgap = 0; agap = 0;
    chk("stall_w_before_load", 64'(w_at >= 3), 64'(1));
    chk("stall_a_before_load", 64'(a_at >= 5), 64'(1));
    chk("stall_loadw_bursts", 64'({lw_rise, lw_cyc}), 64'({32'd1, 32'd3}));
    chk("stall_loada_bursts", 64'({la_rise, la_cyc}), 64'({32'd1, 32'd5}));
    chk("stall_outs", 64'(o_cnt), 64'(3));

    // Config rejection
    clear_mon();
    send_cfg(8'd5, 8'd0);
    send_cfg(8'd17, 8'd5);
    send_cfg(8'd3, 8'd4);
    repeat (3) @(negedge clk);
    chk("rej_err_pulses", 64'(er), 64'(3));
    chk("rej_busy", 64'(busy_cyc), 64'(0));
    chk("rej_strobes", 64'(tog), 64'(0));
    chk("rej_counts_kept", 64'({pe_acount, pe_wcount}), 64'({8'd5, 8'd3}));
    clear_mon();
    push_basic(20'd0, 20'd0, 20'd0);
    exp_q.push_back(20'd14); exp_q.push_back(20'd20); exp_q.push_back(20'd26);
    job(8'd5, 8'd3);
    chk("post_rej_outs", 64'(o_cnt), 64'(3));

    // Full-depth job: acount=16, wcount=1, FIFOs fill to 16
    clear_mon();
    wq.push_back(8'd2);
    for (int i = 1; i <= 16; i++) begin aq.push_back(8'(i)); pq.push_back(20'd0); exp_q.push_back(20'(2 * i)); end
    repeat (24) @(negedge clk);
    chk("full_a_ready", 64'({a_ready, p_ready}), 64'(0));
    job(8'd16, 8'd1);
    chk("full_outs", 64'(o_cnt), 64'(16));

    // Back-to-back with preloaded data
    clear_mon();
    push_basic(20'd0, 20'd0, 20'd0);
    repeat (4) wq.push_back(8'd1);
    for (int i = 2; i <= 5; i++) aq.push_back(8'(i));
    pq.push_back(20'd10);
    exp_q.push_back(20'd14); exp_q.push_back(20'd20); exp_q.push_back(20'd26); exp_q.push_back(20'd24);
    repeat (8) @(negedge clk);
    send_cfg(8'd5, 8'd3);
    send_cfg(8'd4, 8'd4);
    wait_jobs(2);
    chk("b2b_jobs", 64'(jd), 64'(2));
    chk("b2b_outs", 64'(o_cnt), 64'(4));
    chk("b2b_accept_cycle", 64'(acc_t - jd1_t), 64'(1));
    chk("b2b_fill_one_cycle", 64'(la_t - acc_t), 64'(3));
    chk("b2b_drained", 64'(exp_q.size()), 64'(0));

    // Reset during second pe_sums cycle
    clear_mon();
    push_basic(20'd100, 20'd200, 20'd300);
    send_cfg(8'd5, 8'd3);
    n = 0;
    for (int t = 0; t < 500 && n < 2; t++) begin
      if (pe_sums) n++;
      if (n < 2) @(negedge clk);
    end
    chk("rst_reached_sum", 64'(n), 64'(2));
    nrst = 0;
    @(negedge clk);
    chk_zero_outputs("midrst");
    nrst = 1;
    repeat (10) @(negedge clk);
    chk("midrst_no_outputs", 64'(o_cnt), 64'(0));
    chk("midrst_idle", 64'({busy, cfg_ready}), 64'({1'b0, 1'b1}));
    clear_mon();
    push_basic(20'd0, 20'd0, 20'd0);
    exp_q.push_back(20'd14); exp_q.push_back(20'd20); exp_q.push_back(20'd26);
    job(8'd5, 8'd3);
    chk("post_rst_outs", 64'(o_cnt), 64'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
